// File: rtl/vga_pkg.sv
// Shared timing constants, pixel type and fetch FSM states for the VGA line prefetcher.
package vga_pkg;
    localparam int H_VIS_AREA_PXL    = 800;
    localparam int H_WHOLE_LINE_PXL  = 1056;
    localparam int V_VIS_AREA_PXL    = 600;
    localparam int V_WHOLE_FRAME_PXL = 628;

    localparam int CHANNEL_BITS  = 4;
    localparam int CHANNEL_COUNT = 4;
    localparam int PIXEL_BITS    = CHANNEL_BITS * CHANNEL_COUNT;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    typedef enum logic [1:0] { IDLE, REQ, WAIT, ABORT } fetch_state_t;

    function automatic int fb_w(input int h_vis, input int scale_shift);
        return h_vis >> scale_shift;
    endfunction

    function automatic int fb_h(input int v_vis, input int scale_shift);
        return v_vis >> scale_shift;
    endfunction
endpackage

// File: rtl/vga_line_buffer.sv
// Ping-pong line store: one synchronous write port and an asynchronous read
// port so the color path stays combinational (distributed/LUT RAM).
module vga_line_buffer
    import vga_pkg::*;
#(
    parameter int DEPTH     = 400,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 wr_bank,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  pixel_t               wr_data,
    input  logic                 rd_bank,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output pixel_t               rd_data
);
    pixel_t mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_bank][wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_bank][rd_addr];
endmodule

// File: rtl/vga_line_prefetch.sv
// Prefetches the next display line from a downscaled framebuffer into a
// ping-pong line buffer; pixels are served combinationally from the h/v counters.
//
// state | meaning
// IDLE  | no fetch running, waiting for the end-of-visible-line trigger
// REQ   | issuing framebuffer reads for the target row
// WAIT  | all reads issued, collecting the remaining responses
// ABORT | trigger arrived mid-fetch; draining in-flight reads before the pending fetch
module vga_line_prefetch #(
    parameter int H_VIS_AREA_PXL    = vga_pkg::H_VIS_AREA_PXL,
    parameter int V_VIS_AREA_PXL    = vga_pkg::V_VIS_AREA_PXL,
    parameter int V_WHOLE_FRAME_PXL = vga_pkg::V_WHOLE_FRAME_PXL,
    parameter int H_NUM_BITS        = 11,
    parameter int V_NUM_BITS        = 10,
    parameter int SCALE_SHIFT       = 1,
    parameter int FB_ADDR_BITS      = 17,
    parameter int CHANNEL_BITS      = vga_pkg::CHANNEL_BITS,
    parameter int CHANNEL_COUNT     = vga_pkg::CHANNEL_COUNT,
    parameter int MAX_OUTSTANDING   = 8
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [H_NUM_BITS-1:0]                 h_pxl_count,
    input  logic [V_NUM_BITS-1:0]                 v_pxl_count,
    output logic [CHANNEL_COUNT*CHANNEL_BITS-1:0] color,
    output logic                                  fb_rd_req,
    output logic [FB_ADDR_BITS-1:0]               fb_rd_addr,
    input  logic                                  fb_rd_ready,
    input  logic                                  fb_rd_valid,
    input  logic [CHANNEL_COUNT*CHANNEL_BITS-1:0] fb_rd_data,
    output logic                                  fetch_busy,
    output logic                                  underrun
);
    import vga_pkg::*;

    localparam int FB_W     = fb_w(H_VIS_AREA_PXL, SCALE_SHIFT);
    localparam int COL_BITS = $clog2(FB_W);
    localparam int CNT_BITS = $clog2(FB_W + 1);
    localparam int INF_BITS = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_t            state;
    logic [CNT_BITS-1:0]     issued, received;
    logic [INF_BITS-1:0]     inflight;
    logic [FB_ADDR_BITS-1:0] addr;
    logic [V_NUM_BITS-1:0]   pend_line, next_line, start_line;
    logic                    pend_valid, wr_bank;
    logic [1:0]              bank_valid;
    logic                    trigger, next_ok, handshake, resp, accept, start_fetch, visible;
    logic [COL_BITS-1:0]     rd_col;
    pixel_t                  rd_pixel;

    function automatic logic [FB_ADDR_BITS-1:0] row_base(input logic [V_NUM_BITS-1:0] line);
        return FB_ADDR_BITS'(32'(line >> SCALE_SHIFT) * FB_W);
    endfunction

    assign trigger   = h_pxl_count == H_NUM_BITS'(H_VIS_AREA_PXL);
    assign next_line = (v_pxl_count == V_NUM_BITS'(V_WHOLE_FRAME_PXL - 1)) ? '0
                                                                            : v_pxl_count + V_NUM_BITS'(1);
    assign next_ok   = next_line < V_NUM_BITS'(V_VIS_AREA_PXL);

    assign fb_rd_req  = (state == REQ) && (issued < CNT_BITS'(FB_W))
                        && (inflight < INF_BITS'(MAX_OUTSTANDING));
    assign fb_rd_addr = addr;
    assign fetch_busy = state != IDLE;
    assign handshake  = fb_rd_req && fb_rd_ready;
    // A return with nothing outstanding is stale (e.g. from before a reset) and is dropped.
    assign resp       = fb_rd_valid && (inflight != '0);
    assign accept     = resp && (state == REQ || state == WAIT);

    always_comb begin
        start_fetch = 1'b0;
        start_line  = next_line;
        if (state == IDLE) begin
            start_fetch = trigger && next_ok;
        end else if (state == ABORT && !trigger && inflight == '0) begin
            start_fetch = pend_valid;
            start_line  = pend_line;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            issued     <= '0;
            received   <= '0;
            inflight   <= '0;
            addr       <= '0;
            pend_line  <= '0;
            pend_valid <= 1'b0;
            wr_bank    <= 1'b0;
            bank_valid <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            inflight <= inflight + INF_BITS'(handshake) - INF_BITS'(resp);
            if (handshake) begin
                issued <= issued + CNT_BITS'(1);
                addr   <= addr + FB_ADDR_BITS'(1);
            end
            if (accept) received <= received + CNT_BITS'(1);

            case (state)
                IDLE: if (start_fetch) state <= REQ;
                REQ, WAIT: begin
                    if (trigger) begin
                        underrun   <= 1'b1;
                        pend_line  <= next_line;
                        pend_valid <= next_ok;
                        state      <= ABORT;
                    end else if (state == REQ && issued == CNT_BITS'(FB_W)) begin
                        state <= WAIT;
                    end else if (state == WAIT && received == CNT_BITS'(FB_W)) begin
                        bank_valid[wr_bank] <= 1'b1;
                        state               <= IDLE;
                    end
                end
                ABORT: begin
                    if (trigger) begin
                        pend_line  <= next_line;
                        pend_valid <= next_ok;
                    end else if (inflight == '0) begin
                        state <= pend_valid ? REQ : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Overrides the per-cycle counter updates above when a new line begins.
            if (start_fetch) begin
                wr_bank                   <= start_line[0];
                bank_valid[start_line[0]] <= 1'b0;
                issued                    <= '0;
                received                  <= '0;
                addr                      <= row_base(start_line);
            end
        end
    end

    assign visible = (h_pxl_count < H_NUM_BITS'(H_VIS_AREA_PXL))
                     && (v_pxl_count < V_NUM_BITS'(V_VIS_AREA_PXL));
    assign rd_col  = visible ? COL_BITS'(h_pxl_count >> SCALE_SHIFT) : '0;

    vga_line_buffer #(.DEPTH(FB_W)) u_line_buffer (
        .clk     (clk),
        .we      (accept),
        .wr_bank (wr_bank),
        .wr_addr (COL_BITS'(received)),
        .wr_data (fb_rd_data),
        .rd_bank (v_pxl_count[0]),
        .rd_addr (rd_col),
        .rd_data (rd_pixel)
    );

    assign color = (visible && bank_valid[v_pxl_count[0]]) ? rd_pixel : '0;
endmodule
